// File: rtl/mdu_sched.sv
// Shared multiply/divide unit for the two issue slots: arbitrates requests,
// sequences a single-cycle multiply or a bit-serial restoring divide, and owns HI/LO.
module mdu_sched #(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [1:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    input  logic [1:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        flush,
    output logic        grant0,
    output logic        grant1,
    output logic        busy,
    output logic        done_valid,
    output logic        done_slot,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {IDLE, MUL, DIV_RUN, DIV_FIX, DONE} state_t;

    localparam logic [5:0] LAST_ITER = 6'(DIV_ITERS - 1);

    state_t      state;
    logic [1:0]  op_q;
    logic        slot_q;
    logic [31:0] a_q, b_q;
    logic [31:0] quo_q, dvs_q, rem_q;
    logic [5:0]  cnt;

    // Handshake: a request is taken in the cycle its grant is high; an
    // ungranted slot keeps valid and operands stable until it is granted.
    assign grant0 = (state == IDLE) && !flush && req0_valid;
    assign grant1 = (state == IDLE) && !flush && req1_valid && !req0_valid;
    assign busy   = (state != IDLE);

    logic        accept;
    logic [1:0]  sel_op;
    logic [31:0] sel_a, sel_b, a_mag, b_mag;

    always_comb begin
        accept = grant0 | grant1;
        sel_op = grant1 ? req1_op : req0_op;
        sel_a  = grant1 ? req1_a  : req0_a;
        sel_b  = grant1 ? req1_b  : req0_b;
        // op[0]=0 means signed (MULT/DIV): divide runs on magnitudes
        a_mag  = (!sel_op[0] && sel_a[31]) ? -sel_a : sel_a;
        b_mag  = (!sel_op[0] && sel_b[31]) ? -sel_b : sel_b;
    end

    logic [63:0] mul_a, mul_b, product;
    logic [32:0] shifted, diff;
    logic [31:0] quot_fix, rem_fix;

    always_comb begin
        // Low 64 bits of a 64x64 product are right for both signed and unsigned
        mul_a   = op_q[0] ? {32'b0, a_q} : {{32{a_q[31]}}, a_q};
        mul_b   = op_q[0] ? {32'b0, b_q} : {{32{b_q[31]}}, b_q};
        product = mul_a * mul_b;

        shifted = {rem_q, quo_q[31]};
        diff    = shifted - {1'b0, dvs_q};

        quot_fix = (!op_q[0] && (a_q[31] ^ b_q[31])) ? -quo_q : quo_q;
        rem_fix  = (!op_q[0] && a_q[31]) ? -rem_q : rem_q;
        if (b_q == 32'd0) begin
            quot_fix = 32'hFFFF_FFFF;
            rem_fix  = a_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= 2'b00;
            slot_q     <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            cnt        <= '0;
            hi         <= '0;
            lo         <= '0;
            done_valid <= 1'b0;
            done_slot  <= 1'b0;
        end else begin
            done_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= sel_op;
                        slot_q <= grant1;
                        a_q    <= sel_a;
                        b_q    <= sel_b;
                        quo_q  <= a_mag;
                        dvs_q  <= b_mag;
                        rem_q  <= '0;
                        cnt    <= '0;
                        state  <= sel_op[1] ? DIV_RUN : MUL;
                    end
                end
                MUL: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        {hi, lo}   <= product;
                        done_valid <= 1'b1;
                        done_slot  <= slot_q;
                        state      <= DONE;
                    end
                end
                DIV_RUN: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        // Restore when the trial subtraction goes negative
                        if (!diff[32]) begin
                            rem_q <= diff[31:0];
                            quo_q <= {quo_q[30:0], 1'b1};
                        end else begin
                            rem_q <= shifted[31:0];
                            quo_q <= {quo_q[30:0], 1'b0};
                        end
                        cnt <= cnt + 6'd1;
                        if (cnt == LAST_ITER) state <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        hi         <= rem_fix;
                        lo         <= quot_fix;
                        done_valid <= 1'b1;
                        done_slot  <= slot_q;
                        state      <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched: drivers push expected {slot,hi,lo,cycle} into a
// queue; a negedge monitor pops and compares on every done_valid pulse.
module tb_mdu_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, flush;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        grant0, grant1, busy, done_valid, done_slot;
    logic [31:0] hi, lo;

    mdu_sched #(.DIV_ITERS(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .flush(flush), .grant0(grant0), .grant1(grant1), .busy(busy),
        .done_valid(done_valid), .done_slot(done_slot), .hi(hi), .lo(lo)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_errors = 0;
    logic [96:0] exp_q[$];   // {slot, hi, lo, done cycle}
    int t_acc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && done_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                logic [96:0] e;
                e = exp_q.pop_front();
                chk("done_slot", 64'(done_slot), 64'(e[96]));
                chk("hi", 64'(hi), 64'(e[95:64]));
                chk("lo", 64'(lo), 64'(e[63:32]));
                chk("done_cycle", 64'(cyc), 64'(e[31:0]));
            end
        end
    end

    // driver: called at #1 after a posedge with the DUT idle
    task automatic issue0(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int lat,
                          input bit push);
        req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        @(negedge clk);
        chk("grant0", 64'(grant0), 64'd1);
        chk("grant1_idle", 64'(grant1), 64'd0);
        t_acc = cyc;
        if (push) exp_q.push_back({1'b0, eh, el, 32'(cyc + lat)});
        @(posedge clk); #1;
        req0_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        req0_valid = 1'b0; req0_op = 2'b00; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 2'b00; req1_a = '0; req1_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_done", 64'(done_valid), 64'd0);
        chk("rst_slot", 64'(done_slot), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // flush in IDLE suppresses grants
        flush = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("flush_idle_g0", 64'(grant0), 64'd0);
        chk("flush_idle_g1", 64'(grant1), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

        // flush at T+10 of a DIV; new request granted at T+11
        issue0(2'b10, 32'd1000, 32'd3, '0, '0, 34, 1'b0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'd2; req0_b = 32'd3;
        @(negedge clk);
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_hi", 64'(hi), 64'd0);
        chk("flush_lo", 64'(lo), 64'd0);
        chk("flush_done", 64'(done_valid), 64'd0);
        chk("post_flush_grant0", 64'(grant0), 64'd1);
        exp_q.push_back({1'b0, 32'd0, 32'd6, 32'(cyc + 2)});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_drain(50);

        // MULT / MULTU
        issue0(2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 2, 1'b1);
        wait_drain(20);
        issue0(2'b01, 32'hFFFF_FFFE, 32'd3, 32'd2, 32'hFFFF_FFFA, 2, 1'b1);
        wait_drain(20);

        // DIV -7 / 2 with busy window T+1..T+34
        issue0(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 1'b1);
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            chk($sformatf("div_busy_T+%0d", k), 64'(busy), (k <= 34) ? 64'd1 : 64'd0);
        end
        wait_drain(20);

        // simultaneous: req0 MULTU 5*6, req1 DIVU 100/7
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'd5;   req0_b = 32'd6;
        req1_valid = 1'b1; req1_op = 2'b11; req1_a = 32'd100; req1_b = 32'd7;
        @(negedge clk);
        chk("sim_grant0", 64'(grant0), 64'd1);
        chk("sim_grant1", 64'(grant1), 64'd0);
        t_acc = cyc;
        exp_q.push_back({1'b0, 32'd0, 32'd30, 32'(t_acc + 2)});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        begin
            bit got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                @(negedge clk);
                if (grant1) begin
                    got = 1'b1;
                    chk("sim_grant1_cycle", 64'(cyc), 64'(t_acc + 3));
                    exp_q.push_back({1'b1, 32'd2, 32'd14, 32'(cyc + 34)});
                end
            end
            if (!got) begin
                n_checks++;
                n_errors++;
                $display("FAIL sim_grant1_timeout: got no grant1 expected grant at %0d", t_acc + 3);
            end
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_drain(60);

        // divide by zero and signed overflow
        issue0(2'b11, 32'd123, 32'd0, 32'd123, 32'hFFFF_FFFF, 34, 1'b1);
        wait_drain(50);
        issue0(2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 34, 1'b1);
        wait_drain(50);
        issue0(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 34, 1'b1);
        wait_drain(50);
        issue0(2'b00, 32'd7, 32'd9, 32'd0, 32'd63, 2, 1'b1);
        wait_drain(20);

        // async reset mid-DIV at T+5
        issue0(2'b11, 32'd99, 32'd4, '0, '0, 34, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_hi", 64'(hi), 64'd0);
        chk("arst_lo", 64'(lo), 64'd0);
        chk("arst_done", 64'(done_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("arst_idle_busy", 64'(busy), 64'd0);
        chk("arst_idle_lo", 64'(lo), 64'd0);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mdu_sched.md
Name: mdu_sched

Overview:
- Shared multiply/divide scheduler for the dual-issue execute stage.
- The master and slave issue slots both request one multi-cycle MDU: MULT, MULTU, DIV, DIVU.
- The block arbitrates between the two slots, sequences a 2-cycle multiply or a 34-cycle restoring divide, and owns the architectural HI/LO registers.
- It raises busy so the pipeline can stall.

Parameters:
- DIV_ITERS, 32, divide iterations; one quotient bit per cycle.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req0_valid  in  1  master-slot MDU request
- req0_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- req0_a  in  32  rs operand
- req0_b  in  32  rt operand
- req1_valid  in  1  slave-slot request
- req1_op  in  2  same encoding as req0_op
- req1_a  in  32  rs operand
- req1_b  in  32  rt operand
- flush  in  1  pipeline flush (exception/eret); aborts in-flight operation
- grant0  out  1  req0 accepted this cycle
- grant1  out  1  req1 accepted this cycle
- busy  out  1  operation in flight (state != IDLE)
- done_valid  out  1  one-cycle pulse: HI/LO just updated
- done_slot  out  1  0 = master, 1 = slave; owner of the completed op
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; hi=0, lo=0.
  - done_valid=0, done_slot=0, busy=0.
  - Internal counter and operand registers are cleared.
- States: IDLE, MUL, DIV_RUN, DIV_FIX, DONE.
- Grants (combinational, only in IDLE and only when flush=0):
  - grant0 = req0_valid.
  - grant1 = req1_valid & ~req0_valid.
  - Never both high.
  - An ungranted requester holds valid and operands stable until granted.
  - When both slots request in the same cycle, req0 wins. req1 is granted in the first IDLE cycle after req0's DONE, which preserves program order.
- Accept edge: operands, op and slot are registered. Next state is MUL for op[1]=0, else DIV_RUN.
- MUL (1 cycle):
  - 64-bit product of registered operands; signed for MULT, unsigned for MULTU.
  - {hi,lo} <= product on exit.
  - Next state DONE.
- DIV_RUN (DIV_ITERS cycles):
  - Restoring divide on magnitudes; for DIV, |a| and |b| are taken.
  - 6-bit counter counts 0..DIV_ITERS-1; leaves to DIV_FIX when count = DIV_ITERS-1.
- DIV_FIX (1 cycle):
  - Quotient sign = a[31]^b[31]; remainder sign = a[31]. Signs apply only for DIV.
  - hi <= remainder, lo <= quotient.
  - Next state DONE.
- DONE (1 cycle): done_valid=1, done_slot = registered slot. Next state IDLE.
- Latency, counted from the accept cycle T:
  - done_valid is high in cycle T+2 for MUL.
  - done_valid is high in cycle T+DIV_ITERS+2 (=T+34) for DIV.
  - busy is high from T+1 through the DONE cycle inclusive.
  - Earliest next grant is in the cycle after DONE.
- Divide by zero (b=0), for both DIV and DIVU:
  - lo = 32'hFFFF_FFFF, hi = a. No exception; the full iteration count is still spent.
- Signed overflow (DIV, a=32'h8000_0000, b=32'hFFFF_FFFF): lo = 32'h8000_0000, hi = 0.
- Flush:
  - In MUL, DIV_RUN or DIV_FIX: next state IDLE, hi/lo unchanged, no done_valid.
  - In DONE: no effect; the result is already committed.
  - In IDLE: suppresses both grants that cycle.
- hi/lo change only on the MUL or DIV_FIX exit edge. Between operations they hold their value.
- Width rules: the remainder accumulator is 33 bits. Sign fix-up is two's-complement negate in 32 bits.

Test Plan:
- MULT: req0 a=32'hFFFF_FFFE (-2), b=3 at T -> grant0=1 at T; done_valid=1, done_slot=0 at T+2; hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA. Same operands with MULTU -> hi=2, lo=32'hFFFF_FFFA.
- DIV: a=-7 (32'hFFFF_FFF9), b=2 -> done_valid at T+34; lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1); busy=1 for cycles T+1..T+34.
- Simultaneous: req0 MULTU a=5, b=6; req1 DIVU a=100, b=7, both at T -> grant0 at T, done slot 0 (lo=30) at T+2; grant1 at T+3; done slot 1 at T+37 with lo=14, hi=2.
- DIVU a=123, b=0 -> lo=32'hFFFF_FFFF, hi=123 at T+34. DIV a=32'h8000_0000, b=-1 -> lo=32'h8000_0000, hi=0.
- Flush at T+10 of a DIV issued with hi=lo=0 -> state IDLE at T+11, busy=0, no done_valid, hi=lo=0. A new req0 at T+11 is granted.
- Assert rst mid-DIV at T+5 -> busy=0, hi=lo=0, done_valid=0 immediately (async). No completion after rst is released.
